act_broadcast_sched: RTL and testbench
======================================

Name: act_broadcast_sched

Overview:
- Top-level layer scheduler for the PE array.
- Per layer, it pulses pe_start_calc to all PEs, then streams the layer's input activations from the activation memory onto the shared broadcast bus, dropping zero values.
- Once every non-zero activation has gone out, it signals fin_broadcast, waits for fin_comp from every PE, then pulses layer_done.
- It repeats this for layer_no layers, then returns to idle.

Parameters:
- NUM_PE, 64, number of PEs on the broadcast bus.
- DATA_W, 16, activation value width.
- ADDR_W, 12, input activation index width.
- LAYER_W, 4, layer counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  start network; sampled in IDLE only
- layer_no  in  LAYER_W  total layers; a value of 0 makes start ignored
- in_act_no  in  ADDR_W+1  input activations per layer; held stable while busy
- act_rd_en  out  1  activation memory read strobe
- act_rd_addr  out  ADDR_W  read address, relative to the layer
- act_rd_data  in  DATA_W  read data, valid exactly 1 cycle after act_rd_en
- pe_queue_full  in  NUM_PE  per-PE activation queue full
- bc_valid  out  1  broadcast word valid
- bc_idx  out  ADDR_W  broadcast activation index
- bc_data  out  DATA_W  broadcast activation value
- pe_start_calc  out  1  1-cycle start pulse to all PEs
- fin_broadcast  out  1  1-cycle "broadcast finished" pulse
- pe_fin_comp  in  NUM_PE  per-PE computation-finished pulses
- layer_done  out  1  1-cycle layer-complete pulse
- layer_idx  out  LAYER_W  current layer
- busy  out  1  asserted whenever state is not IDLE
- all_done  out  1  1-cycle pulse, coincident with the final layer_done

Behaviour:
- Reset values: all outputs 0; state IDLE; layer_idx 0; rd_ptr 0; FIFO empty; fin_mask 0; in-flight flag 0.
- States: IDLE, START, BCAST, FIN_BC, WAIT_COMP, LAYER_END.
- IDLE:
  - start & layer_no != 0 -> START, layer_idx <= 0.
  - start while busy is ignored.
- START:
  - pe_start_calc = 1 for one cycle; rd_ptr <= 0; fin_mask <= 0; -> BCAST.
- BCAST, read side:
  - act_rd_en = 1 when rd_ptr < in_act_no and (FIFO occupancy + in-flight read) < 2.
  - act_rd_addr = rd_ptr; rd_ptr increments on every issued read.
  - Returned data goes into a 2-entry buffer tagged with its index, but only if non-zero; zero data is discarded.
- BCAST, broadcast side:
  - bc_valid = FIFO non-empty & ~|pe_queue_full; bc_idx and bc_data come from the FIFO head.
  - The head pops when bc_valid = 1; one word per cycle at most.
  - When bc_valid = 0, bc_idx and bc_data are 0.
- Throughput: steady-state 1 activation per cycle with no backpressure. First bc_valid appears 2 cycles after entering BCAST.
- Backpressure: any single full bit stalls the broadcast. Reads stop once occupancy reaches 2; the in-flight read is always absorbed by the buffer.
- BCAST exit: rd_ptr == in_act_no & no read in flight & FIFO empty -> FIN_BC. With in_act_no == 0 this exit is taken on the first BCAST cycle.
- FIN_BC:
  - fin_broadcast = 1 for one cycle; -> WAIT_COMP.
  - fin_mask also captures pe_fin_comp in this state, because PEs may finish in the same cycle.
- WAIT_COMP:
  - fin_mask |= pe_fin_comp each cycle.
  - When (fin_mask | pe_fin_comp) is all ones -> LAYER_END.
  - Duplicate fin_comp pulses are harmless.
- LAYER_END:
  - layer_done = 1 for one cycle.
  - If layer_idx == layer_no-1: all_done = 1, layer_idx <= 0, -> IDLE.
  - Else: layer_idx <= layer_idx+1, -> START.
  - The START cycle immediately after LAYER_END is required, because PEs return to idle on layer_done.
- Reset mid-operation: all state cleared immediately; no pulses are emitted; any read still in flight is discarded.

Decomposition:
- Shared package/header entries: state encodings (4-bit, IDLE = 0), NUM_PE, DATA_W, ADDR_W and LAYER_W defaults, and the broadcast word width macro (ADDR_W+DATA_W).
- One sub-module: bc_skid_fifo, a 2-entry FIFO.
  - Width ADDR_W+DATA_W; push, pop, full, empty, count outputs.
  - Simultaneous push/pop when full is allowed and must work.

Test Plan:
- Zero skipping: layer_no=1, in_act_no=4, data {5,0,7,0}, no full -> bc_valid words (0,5) and (2,7) only; then fin_broadcast; all pe_fin_comp pulsed 3 cycles later -> layer_done and all_done on the same cycle.
- Throughput: in_act_no=8, all data non-zero -> bc_valid high 8 consecutive cycles, indices 0..7 in order.
- Backpressure: pe_queue_full[17]=1 for 5 cycles mid-stream -> bc_valid=0 during those cycles, no word lost or duplicated, never more than 1 read issued while the FIFO is full.
- Completion collection: PE fin_comp pulses staggered over 10 cycles, PE 63 pulsing during the FIN_BC cycle -> layer_done only after the last distinct PE pulse.
- Multi-layer and empty layer: layer_no=3, in_act_no=0 -> per layer START, BCAST, FIN_BC, ...; layer_idx steps 0, 1, 2; all_done once; busy drops afterwards.
- Reset mid-BCAST: assert rst with 1 word in the FIFO -> all outputs 0 next cycle; a subsequent start behaves as from power-up.

Source files
------------

// File: rtl/act_broadcast_sched_pkg.sv
// Shared encodings and default widths for the activation broadcast scheduler.
// The broadcast word packs {index, value}, with the index in the upper bits.
package act_broadcast_sched_pkg;

  localparam int NUM_PE_D  = 64;
  localparam int DATA_W_D  = 16;
  localparam int ADDR_W_D  = 12;
  localparam int LAYER_W_D = 4;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_START     = 4'd1;
  localparam logic [3:0] ST_BCAST     = 4'd2;
  localparam logic [3:0] ST_FIN_BC    = 4'd3;
  localparam logic [3:0] ST_WAIT_COMP = 4'd4;
  localparam logic [3:0] ST_LAYER_END = 4'd5;

  function automatic int bc_word_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/act_broadcast_sched_fifo.sv
// Two-entry skid buffer for tagged activation words.
// A push is accepted when full as long as a pop happens in the same cycle.
module bc_skid_fifo #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/act_broadcast_sched.sv
// Layer scheduler: starts the PEs, streams non-zero activations onto the
// broadcast bus, collects per-PE completion, and steps through the layers.
module act_broadcast_sched
  import act_broadcast_sched_pkg::*;
#(
  parameter int NUM_PE  = NUM_PE_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int LAYER_W = LAYER_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer_no,
  input  logic [ADDR_W:0]    in_act_no,
  output logic               act_rd_en,
  output logic [ADDR_W-1:0]  act_rd_addr,
  input  logic [DATA_W-1:0]  act_rd_data,
  input  logic [NUM_PE-1:0]  pe_queue_full,
  output logic               bc_valid,
  output logic [ADDR_W-1:0]  bc_idx,
  output logic [DATA_W-1:0]  bc_data,
  output logic               pe_start_calc,
  output logic               fin_broadcast,
  input  logic [NUM_PE-1:0]  pe_fin_comp,
  output logic               layer_done,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               all_done
);

  localparam int WORD_W = bc_word_w(ADDR_W, DATA_W);

  logic [3:0]        state;
  logic [ADDR_W:0]   rd_ptr;
  logic [NUM_PE-1:0] fin_mask;
  logic              vld_p1;
  logic [ADDR_W-1:0] idx_p1;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [WORD_W-1:0] fifo_din;
  logic [WORD_W-1:0] fifo_dout;

  logic              in_bcast;
  logic [2:0]        occ_next;
  logic              bcast_exit;
  logic              comp_all;
  logic              last_layer;

  assign in_bcast = (state == ST_BCAST);
  assign fifo_pop = in_bcast & ~fifo_empty & ~(|pe_queue_full);

  // Occupancy after this cycle's pop plus the read already in flight; keeping
  // it below 2 guarantees the next returned word always has a slot.
  assign occ_next    = {1'b0, fifo_count} - {2'b0, fifo_pop} + {2'b0, vld_p1};
  assign act_rd_en   = in_bcast & (rd_ptr < in_act_no) & (occ_next < 3'd2);
  assign act_rd_addr = rd_ptr[ADDR_W-1:0];

  assign fifo_push = vld_p1 & (act_rd_data != '0) & (~fifo_full | fifo_pop);
  assign fifo_din  = {idx_p1, act_rd_data};

  assign bc_valid = fifo_pop;
  assign bc_idx   = bc_valid ? fifo_dout[WORD_W-1:DATA_W] : '0;
  assign bc_data  = bc_valid ? fifo_dout[DATA_W-1:0] : '0;

  assign bcast_exit = in_bcast & (rd_ptr == in_act_no) & ~vld_p1 & fifo_empty;
  assign comp_all   = &(fin_mask | pe_fin_comp);
  assign last_layer = (layer_idx == (layer_no - LAYER_W'(1)));

  assign pe_start_calc = (state == ST_START);
  assign fin_broadcast = (state == ST_FIN_BC);
  assign layer_done    = (state == ST_LAYER_END);
  assign all_done      = layer_done & last_layer;
  assign busy          = (state != ST_IDLE);

  bc_skid_fifo #(
    .W(WORD_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (fifo_din),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // p0 -> p1: read issued this cycle, data returns next cycle
  always_ff @(posedge clk) begin
    if (act_rd_en) idx_p1 <= rd_ptr[ADDR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      layer_idx <= '0;
      rd_ptr    <= '0;
      fin_mask  <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= act_rd_en;
      if (act_rd_en) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      case (state)
        ST_IDLE: begin
          if (start && (layer_no != '0)) begin
            state     <= ST_START;
            layer_idx <= '0;
          end
        end
        ST_START: begin
          rd_ptr   <= '0;
          fin_mask <= '0;
          state    <= ST_BCAST;
        end
        ST_BCAST: begin
          if (bcast_exit) state <= ST_FIN_BC;
        end
        ST_FIN_BC: begin
          fin_mask <= fin_mask | pe_fin_comp;
          state    <= ST_WAIT_COMP;
        end
        ST_WAIT_COMP: begin
          fin_mask <= fin_mask | pe_fin_comp;
          if (comp_all) state <= ST_LAYER_END;
        end
        ST_LAYER_END: begin
          if (last_layer) begin
            layer_idx <= '0;
            state     <= ST_IDLE;
          end else begin
            layer_idx <= layer_idx + LAYER_W'(1);
            state     <= ST_START;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_broadcast_sched.sv
// Directed bench for act_broadcast_sched: a cycle-exact vector table for the
// zero-skipping layer, then sequences for throughput, stalls, completion and reset.
module tb_act_broadcast_sched;

  localparam int NUM_PE = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  layer_no = '0;
  logic [12:0] in_act_no = '0;
  logic        act_rd_en;
  logic [11:0] act_rd_addr;
  logic [15:0] act_rd_data = '0;
  logic [63:0] pe_queue_full = '0;
  logic        bc_valid;
  logic [11:0] bc_idx;
  logic [15:0] bc_data;
  logic        pe_start_calc;
  logic        fin_broadcast;
  logic [63:0] pe_fin_comp = '0;
  logic        layer_done;
  logic [3:0]  layer_idx;
  logic        busy;
  logic        all_done;

  act_broadcast_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .layer_no     (layer_no),
    .in_act_no    (in_act_no),
    .act_rd_en    (act_rd_en),
    .act_rd_addr  (act_rd_addr),
    .act_rd_data  (act_rd_data),
    .pe_queue_full(pe_queue_full),
    .bc_valid     (bc_valid),
    .bc_idx       (bc_idx),
    .bc_data      (bc_data),
    .pe_start_calc(pe_start_calc),
    .fin_broadcast(fin_broadcast),
    .pe_fin_comp  (pe_fin_comp),
    .layer_done   (layer_done),
    .layer_idx    (layer_idx),
    .busy         (busy),
    .all_done     (all_done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:63];

  // Activation memory: data for a strobe seen in one cycle appears in the next;
  // cycles without a read return a non-zero filler that must never be used.
  always begin : rd_model
    logic        p;
    logic [11:0] a;
    @(negedge clk);
    p = act_rd_en;
    a = act_rd_addr;
    @(posedge clk);
    #1;
    act_rd_data = p ? mem[a[5:0]] : 16'hBEEF;
  end

  int vec_n = 0;
  int miss_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [50:0] outs();
    return {busy, pe_start_calc, act_rd_en, act_rd_addr, bc_valid, bc_idx, bc_data,
            fin_broadcast, layer_done, all_done, layer_idx};
  endfunction

  typedef struct packed {
    logic        start;
    logic        fin_all;
    logic [50:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic fa, input logic b, input logic ps,
                              input logic re, input logic [11:0] ra, input logic bv,
                              input logic [11:0] bi, input logic [15:0] bd, input logic fb,
                              input logic ld, input logic ad);
    vec_t v;
    v.start   = st;
    v.fin_all = fa;
    v.exp     = {b, ps, re, ra, bv, bi, bd, fb, ld, ad, 4'd0};
    return v;
  endfunction

  // Sequence metrics, refreshed by run()
  int st_cyc, fv_cyc, fin_cyc, ld_cyc, n_start, n_ld, n_ad, ad_bad, gap_bad;
  int n_words, run_len, max_run, n_stall, stall_reads, stall_valid;
  logic [3:0]  lidx_log[$];
  logic [27:0] expq[$];

  task automatic run(input int nl, input int nact, input int stall_off, input bit stagger,
                     input int max_cyc, output bit timed_out);
    logic [27:0] e;
    bit done;
    int c;
    layer_no = 4'(nl);
    in_act_no = 13'(nact);
    st_cyc = -1; fv_cyc = -1; fin_cyc = -1; ld_cyc = -1;
    n_start = 0; n_ld = 0; n_ad = 0; ad_bad = 0; gap_bad = 0;
    n_words = 0; run_len = 0; max_run = 0; n_stall = 0; stall_reads = 0; stall_valid = 0;
    lidx_log.delete();
    expq.delete();
    done = 0;
    c = 0;
    start = 1'b1;
    while (!done && c < max_cyc) begin
      @(negedge clk);
      if (pe_start_calc) begin
        n_start++;
        if (ld_cyc >= 0 && c - ld_cyc != 1) gap_bad++;
        st_cyc = c; fv_cyc = -1; fin_cyc = -1;
        lidx_log.push_back(layer_idx);
        expq.delete();
        for (int i = 0; i < nact; i++)
          if (mem[i] != 16'd0) expq.push_back({12'(i), mem[i]});
      end
      if (|pe_queue_full) begin
        n_stall++;
        if (act_rd_en) stall_reads++;
        if (bc_valid) stall_valid++;
      end
      if (bc_valid) begin
        if (fv_cyc < 0) fv_cyc = c;
        n_words++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        e = (expq.size() > 0) ? expq.pop_front() : 'x;
        chk("bc_word", {bc_idx, bc_data}, e);
      end else begin
        run_len = 0;
      end
      if (fin_broadcast) begin
        fin_cyc = c;
        if (stagger) pe_fin_comp[63] = 1'b1;
      end
      if (layer_done) begin
        n_ld++;
        ld_cyc = c;
      end
      if (all_done) begin
        n_ad++;
        if (!layer_done) ad_bad++;
      end
      if (c > 2 && !busy) done = 1;
      @(posedge clk);
      #1;
      start = 1'b0;
      pe_fin_comp = '0;
      pe_queue_full = (stall_off >= 0 && fv_cyc >= 0 && c + 1 >= fv_cyc + stall_off &&
                       c + 1 < fv_cyc + stall_off + 5) ? (64'd1 << 17) : '0;
      if (fin_cyc >= 0) begin
        if (!stagger && c + 1 - fin_cyc == 3) pe_fin_comp = '1;
        if (stagger && c + 1 - fin_cyc >= 1 && c + 1 - fin_cyc <= 10) begin
          for (int p = 0; p < NUM_PE - 1; p++)
            if (p % 10 == c - fin_cyc) pe_fin_comp[p] = 1'b1;
          pe_fin_comp[0] = 1'b1;
        end
      end
      c++;
    end
    timed_out = !done;
  endtask

  vec_t tv[14];
  bit   to;
  bit   seen;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'(outs()), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero skipping: data {5,0,7,0}, one layer, all PEs finish 3 cycles after fin_broadcast
    mem[0] = 16'd5; mem[1] = 16'd0; mem[2] = 16'd7; mem[3] = 16'd0;
    layer_no = 4'd1;
    in_act_no = 13'd4;
    tv[0]  = mk(1, 0, 0, 0, 0, 12'd0, 0, 12'd0, 16'd0, 0, 0, 0);
    tv[1]  = mk(0, 0, 1, 1, 0, 12'd0, 0, 12'd0, 16'd0, 0, 0, 0);
    tv[2]  = mk(0, 0, 1, 0, 1, 12'd0, 0, 12'd0, 16'd0, 0, 0, 0);
    tv[3]  = mk(0, 0, 1, 0, 1, 12'd1, 0, 12'd0, 16'd0, 0, 0, 0);
    tv[4]  = mk(0, 0, 1, 0, 1, 12'd2, 1, 12'd0, 16'd5, 0, 0, 0);
    tv[5]  = mk(0, 0, 1, 0, 1, 12'd3, 0, 12'd0, 16'd0, 0, 0, 0);
    tv[6]  = mk(0, 0, 1, 0, 0, 12'd4, 1, 12'd2, 16'd7, 0, 0, 0);
    tv[7]  = mk(0, 0, 1, 0, 0, 12'd4, 0, 12'd0, 16'd0, 0, 0, 0);
    tv[8]  = mk(0, 0, 1, 0, 0, 12'd4, 0, 12'd0, 16'd0, 1, 0, 0);
    tv[9]  = mk(0, 0, 1, 0, 0, 12'd4, 0, 12'd0, 16'd0, 0, 0, 0);
    tv[10] = mk(0, 0, 1, 0, 0, 12'd4, 0, 12'd0, 16'd0, 0, 0, 0);
    tv[11] = mk(0, 1, 1, 0, 0, 12'd4, 0, 12'd0, 16'd0, 0, 0, 0);
    tv[12] = mk(0, 0, 1, 0, 0, 12'd4, 0, 12'd0, 16'd0, 0, 1, 1);
    tv[13] = mk(0, 0, 0, 0, 0, 12'd4, 0, 12'd0, 16'd0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      start = tv[i].start;
      pe_fin_comp = tv[i].fin_all ? '1 : '0;
      @(negedge clk);
      chk($sformatf("zs_vec%0d", i), 64'(outs()), 64'(tv[i].exp));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    pe_fin_comp = '0;

    // Throughput: 8 non-zero activations stream back to back
    for (int i = 0; i < 8; i++) mem[i] = 16'h100 + 16'(i);
    run(1, 8, -1, 0, 200, to);
    chk("tp_timeout", 64'(to), 64'd0);
    chk("tp_words", 64'(n_words), 64'd8);
    chk("tp_run", 64'(max_run), 64'd8);
    chk("tp_latency", 64'(fv_cyc - st_cyc), 64'd3);
    chk("tp_leftover", 64'(expq.size()), 64'd0);
    chk("tp_done_lat", 64'(ld_cyc - fin_cyc), 64'd4);
    chk("tp_all_done", 64'(n_ad), 64'd1);

    // Backpressure: PE 17 full for 5 cycles mid-stream, two zeros in the data
    for (int i = 0; i < 12; i++) mem[i] = (i == 3 || i == 8) ? 16'd0 : 16'h200 + 16'(i);
    run(1, 12, 2, 0, 300, to);
    chk("bp_timeout", 64'(to), 64'd0);
    chk("bp_stall_cycles", 64'(n_stall), 64'd5);
    chk("bp_valid_in_stall", 64'(stall_valid), 64'd0);
    chk("bp_reads_in_stall_le1", 64'(stall_reads <= 1), 64'd1);
    chk("bp_words", 64'(n_words), 64'd10);
    chk("bp_leftover", 64'(expq.size()), 64'd0);

    // Completion: staggered pulses over 10 cycles, PE 63 only during FIN_BC
    mem[0] = 16'd5; mem[1] = 16'd0; mem[2] = 16'd7; mem[3] = 16'd0;
    run(1, 4, -1, 1, 300, to);
    chk("cc_timeout", 64'(to), 64'd0);
    chk("cc_done_lat", 64'(ld_cyc - fin_cyc), 64'd11);
    chk("cc_words", 64'(n_words), 64'd2);

    // Multi-layer with empty layers
    run(3, 0, -1, 0, 300, to);
    chk("ml_timeout", 64'(to), 64'd0);
    chk("ml_starts", 64'(n_start), 64'd3);
    chk("ml_layer_idx", (lidx_log.size() == 3) ? 64'({lidx_log[0], lidx_log[1], lidx_log[2]}) : 64'hFFF,
        64'h012);
    chk("ml_layer_done", 64'(n_ld), 64'd3);
    chk("ml_all_done", 64'(n_ad), 64'd1);
    chk("ml_all_done_align", 64'(ad_bad), 64'd0);
    chk("ml_restart_gap", 64'(gap_bad), 64'd0);
    chk("ml_empty_bcast", 64'(fin_cyc - st_cyc), 64'd2);
    chk("ml_words", 64'(n_words), 64'd0);
    @(negedge clk);
    chk("ml_busy_after", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Reset while a word sits in the FIFO, then a fresh run
    for (int i = 0; i < 8; i++) mem[i] = 16'h300 + 16'(i);
    layer_no = 4'd1;
    in_act_no = 13'd8;
    start = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bc_valid) begin
        seen = 1;
        rst = 1'b1;
      end else begin
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    start = 1'b0;
    chk("rst_reached_stream", 64'(seen), 64'd1);
    @(negedge clk);
    chk("rst_mid_outs", 64'(outs()), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(1, 8, -1, 0, 200, to);
    chk("rst_rerun_timeout", 64'(to), 64'd0);
    chk("rst_rerun_words", 64'(n_words), 64'd8);
    chk("rst_rerun_latency", 64'(fv_cyc - st_cyc), 64'd3);
    chk("rst_rerun_leftover", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
